prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 111 +++++++++++
 tb/tb_prog_clock_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Programmable clock divider: a registered square wave and a one-cycle tick per period of N clocks.
// A new divisor is held pending and applied only at a period boundary (or while idle), so periods are never cut.
module prog_clock_divider #(
  parameter int WIDTH           = 16,
  parameter int DEFAULT_DIVISOR = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             divisor_load,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             divided_clock,
  output logic             tick,
  output logic [WIDTH-1:0] divisor_active,
  output logic             load_pending,
  output logic             load_error
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [WIDTH-1:0] divisor_next;
  logic [WIDTH-1:0] high_len;
  logic             divided_clock_next, tick_next, load_pending_next, load_error_next;
  logic             load_ok, load_bad, wrap, apply;

  assign load_ok  = divisor_load && (divisor_in >= WIDTH'(2));
  assign load_bad = divisor_load && (divisor_in <  WIDTH'(2));
  assign wrap     = (state == RUN) && enable && (count == divisor_active - WIDTH'(1));
  assign apply    = load_pending && ((state == IDLE) || wrap);
  // Odd divisors get the extra cycle in the high phase.
  assign high_len = divisor_active - (divisor_active >> 1);

  always_comb begin
    state_next         = state;
    count_next         = count;
    divided_clock_next = divided_clock;
    tick_next          = tick;
    divisor_next       = divisor_active;
    pending_next       = pending;
    load_pending_next  = load_pending;
    load_error_next    = load_bad;

    if (apply) begin
      divisor_next      = pending;
      load_pending_next = 1'b0;
    end

    case (state)
      IDLE: begin
        count_next         = '0;
        divided_clock_next = 1'b0;
        tick_next          = 1'b0;
        if (enable) begin
          state_next         = RUN;
          divided_clock_next = 1'b1;
          tick_next          = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next         = IDLE;
          count_next         = '0;
          divided_clock_next = 1'b0;
          tick_next          = 1'b0;
        end else if (wrap) begin
          count_next         = '0;
          divided_clock_next = 1'b1;
          tick_next          = 1'b1;
        end else begin
          // Outputs are computed from the next count so they line up with it.
          count_next         = count + WIDTH'(1);
          divided_clock_next = (count_next < high_len);
          tick_next          = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // A load on the same edge as an application becomes the new pending value.
    if (load_ok) begin
      pending_next      = divisor_in;
      load_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      divided_clock  <= 1'b0;
      tick           <= 1'b0;
      divisor_active <= WIDTH'(DEFAULT_DIVISOR);
      pending        <= WIDTH'(DEFAULT_DIVISOR);
      load_pending   <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      divided_clock  <= divided_clock_next;
      tick           <= tick_next;
      divisor_active <= divisor_next;
      pending        <= pending_next;
      load_pending   <= load_pending_next;
      load_error     <= load_error_next;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: hand-computed waveforms for several divisors,
// load timing around wrap edges, rejected loads, enable drop and mid-period reset.
module tb_prog_clock_divider;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         divisor_load;
  logic [W-1:0] divisor_in;
  logic         divided_clock;
  logic         tick;
  logic [W-1:0] divisor_active;
  logic         load_pending;
  logic         load_error;

  int checks = 0;
  int errors = 0;

  prog_clock_divider #(.WIDTH(W), .DEFAULT_DIVISOR(50)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .divisor_load   (divisor_load),
    .divisor_in     (divisor_in),
    .divided_clock  (divided_clock),
    .tick           (tick),
    .divisor_active (divisor_active),
    .load_pending   (load_pending),
    .load_error     (load_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Steps `cycles` edges; period counts start+0 .. wrap modulo n.
  task automatic run_expect(input string tag, input int n, input int start, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      int c;
      c = (start + i) % n;
      step();
      check({tag, "_dc"},   {31'b0, divided_clock}, {31'b0, (c < (n - n / 2))});
      check({tag, "_tick"}, {31'b0, tick},          {31'b0, (c == 0)});
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; divisor_load = 1'b0; divisor_in = '0;
    step(); step();
    check("rst_dc",   {31'b0, divided_clock}, 0);
    check("rst_tick", {31'b0, tick},          0);
    check("rst_div",  {24'b0, divisor_active}, 50);
    check("rst_lp",   {31'b0, load_pending},  0);
    check("rst_le",   {31'b0, load_error},    0);
    reset = 1'b0;

    // Load 4 while idle: pending for one edge, then applied.
    divisor_load = 1'b1; divisor_in = 8'd4;
    step();
    check("idle_load_lp",  {31'b0, load_pending},   1);
    check("idle_load_div", {24'b0, divisor_active}, 50);
    divisor_load = 1'b0;
    step();
    check("idle_apply_div", {24'b0, divisor_active}, 4);
    check("idle_apply_lp",  {31'b0, load_pending},   0);
    check("idle_dc",        {31'b0, divided_clock},  0);

    enable = 1'b1;
    run_expect("n4", 4, 0, 8);
    check("n4_div", {24'b0, divisor_active}, 4);

    // N=4, load 6 at count=1: pending until the wrap, then a 6-cycle period.
    run_expect("n4a", 4, 0, 2);
    divisor_load = 1'b1; divisor_in = 8'd6;
    step();
    check("ld6_lp",  {31'b0, load_pending},   1);
    check("ld6_div", {24'b0, divisor_active}, 4);
    check("ld6_dc",  {31'b0, divided_clock},  0);
    divisor_load = 1'b0;
    step();
    check("ld6_lp2", {31'b0, load_pending}, 1);
    run_expect("n6", 6, 0, 12);
    check("n6_div", {24'b0, divisor_active}, 6);
    check("n6_lp",  {31'b0, load_pending},   0);

    // Drop enable at count=2, then restart.
    run_expect("n6b", 6, 0, 3);
    enable = 1'b0;
    step();
    check("off_dc",   {31'b0, divided_clock}, 0);
    check("off_tick", {31'b0, tick},          0);
    step();
    check("off_dc2",  {31'b0, divided_clock}, 0);
    enable = 1'b1;
    run_expect("n6c", 6, 0, 6);

    // Load on the wrap edge: the period starting there still uses 6.
    divisor_load = 1'b1; divisor_in = 8'd4;
    step();
    check("wrapld_lp",   {31'b0, load_pending},   1);
    check("wrapld_div",  {24'b0, divisor_active}, 6);
    check("wrapld_tick", {31'b0, tick},           1);
    divisor_load = 1'b0;
    run_expect("n6w", 6, 1, 5);
    run_expect("n4b", 4, 0, 4);
    check("n4b_div", {24'b0, divisor_active}, 4);
    check("n4b_lp",  {31'b0, load_pending},   0);

    // Rejected load of 1: one-cycle error pulse, waveform unchanged.
    divisor_load = 1'b1; divisor_in = 8'd1;
    step();
    check("err_le",   {31'b0, load_error},     1);
    check("err_div",  {24'b0, divisor_active}, 4);
    check("err_lp",   {31'b0, load_pending},   0);
    check("err_tick", {31'b0, tick},           1);
    divisor_load = 1'b0;
    step();
    check("err_le2",  {31'b0, load_error},     0);
    check("err_dc",   {31'b0, divided_clock},  1);
    run_expect("n4err", 4, 2, 6);

    // Load 5 on a wrap edge, then odd period 1,1,1,0,0.
    divisor_load = 1'b1; divisor_in = 8'd5;
    step();
    check("ld5_lp", {31'b0, load_pending}, 1);
    divisor_load = 1'b0;
    run_expect("n4pre", 4, 1, 3);
    run_expect("n5", 5, 0, 10);
    check("n5_div", {24'b0, divisor_active}, 5);

    // Second load before application overwrites the first.
    divisor_load = 1'b1; divisor_in = 8'd7;
    step();
    divisor_in = 8'd3;
    step();
    divisor_load = 1'b0;
    check("ovw_lp", {31'b0, load_pending}, 1);
    run_expect("n5ov", 5, 2, 3);
    run_expect("n3", 3, 0, 6);
    check("n3_div", {24'b0, divisor_active}, 3);

    // Reset mid-period discards the pending load; RUN resumes with the default.
    divisor_load = 1'b1; divisor_in = 8'd9;
    step();
    check("pre_rst_lp", {31'b0, load_pending}, 1);
    divisor_load = 1'b0;
    reset = 1'b1;
    step();
    check("mrst_dc",   {31'b0, divided_clock},  0);
    check("mrst_tick", {31'b0, tick},           0);
    check("mrst_lp",   {31'b0, load_pending},   0);
    check("mrst_div",  {24'b0, divisor_active}, 50);
    reset = 1'b0;
    run_expect("n50", 50, 0, 31);
    check("n50_div", {24'b0, divisor_active}, 50);

    // Largest divisor 2^W-1 = 255, including the 254 -> 0 wrap.
    divisor_load = 1'b1; divisor_in = 8'd255;
    step();
    check("ld255_lp", {31'b0, load_pending}, 1);
    divisor_load = 1'b0;
    run_expect("n50b", 50, 32, 18);
    run_expect("n255", 255, 0, 260);
    check("n255_div", {24'b0, divisor_active}, 255);

    // Smallest divisor 2, loaded while idle.
    enable = 1'b0;
    step();
    divisor_load = 1'b1; divisor_in = 8'd2;
    step();
    divisor_load = 1'b0;
    step();
    check("n2_div", {24'b0, divisor_active}, 2);
    enable = 1'b1;
    run_expect("n2", 2, 0, 6);

    // Load of 0 is also rejected.
    divisor_load = 1'b1; divisor_in = 8'd0;
    step();
    divisor_load = 1'b0;
    check("err0_le",  {31'b0, load_error},     1);
    check("err0_div", {24'b0, divisor_active}, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
